// File: rtl/l1d_mshr_table.sv
// rtl/l1d_mshr_table.sv - L1D miss status holding register table with lookup and registered release port
package l1d_mshr_pkg;
  localparam int INDEX_W = 4;
  localparam int TAG_W   = 4;

  typedef struct packed {
    logic               need_evict;
    logic               need_linefill;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   new_tag;
    logic [TAG_W-1:0]   evict_tag;
  } pack_l1d_mshr_state;
endpackage

module l1d_mshr_table
  import l1d_mshr_pkg::*;
#(
  parameter int ENTRY_NUM   = 32,
  parameter int ID_WIDTH    = 5,
  parameter int INDEX_WIDTH = INDEX_W,
  parameter int TAG_WIDTH   = TAG_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_vld,
  output logic                   alloc_rdy,
  input  pack_l1d_mshr_state     alloc_state,
  output logic [ID_WIDTH-1:0]    alloc_id,
  input  logic [INDEX_WIDTH-1:0] lkp_index,
  output logic                   lkp_hit,
  output logic [ID_WIDTH-1:0]    lkp_hit_id,
  input  logic                   evict_done_vld,
  input  logic [ID_WIDTH-1:0]    evict_done_id,
  input  logic                   lfill_done_vld,
  input  logic [ID_WIDTH-1:0]    lfill_done_id,
  output logic                   rel_vld,
  output logic [ID_WIDTH-1:0]    rel_id,
  output pack_l1d_mshr_state     rel_state,
  input  logic                   rel_rdy,
  output logic [ID_WIDTH:0]      busy_cnt,
  output logic                   full
);

  // Entries keep the packed state as a flat vector; the index field sits above both tags.
  localparam int STATE_W = 2 + INDEX_WIDTH + 2 * TAG_WIDTH;
  localparam int IDX_LSB = 2 * TAG_WIDTH;

  typedef enum logic [1:0] {E_IDLE, E_WAIT, E_DONE} entry_e;

  entry_e               st_q   [ENTRY_NUM];
  entry_e               st_d   [ENTRY_NUM];
  logic [STATE_W-1:0]   data_q [ENTRY_NUM];
  logic [STATE_W-1:0]   data_d [ENTRY_NUM];
  logic [ENTRY_NUM-1:0] ev_p_q, ev_p_d, lf_p_q, lf_p_d;

  logic                 rel_vld_q, rel_vld_d;
  logic [ID_WIDTH-1:0]  rel_id_q, rel_id_d;
  pack_l1d_mshr_state   rel_state_q, rel_state_d;
  logic [ID_WIDTH:0]    busy_q, busy_d;

  logic                 accept, rel_fire;
  logic [ID_WIDTH-1:0]  free_id, done_id;
  logic                 done_found;

  assign full      = (busy_q == (ID_WIDTH+1)'(ENTRY_NUM));
  assign alloc_rdy = !full;
  assign alloc_id  = full ? '0 : free_id;
  assign accept    = alloc_vld && alloc_rdy;
  assign rel_fire  = rel_vld_q && rel_rdy;

  assign rel_vld   = rel_vld_q;
  assign rel_id    = rel_id_q;
  assign rel_state = rel_state_q;
  assign busy_cnt  = busy_q;

  // Descending scans so the lowest matching id is the last one written.
  always_comb begin
    free_id    = '0;
    lkp_hit    = 1'b0;
    lkp_hit_id = '0;
    done_found = 1'b0;
    done_id    = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (st_q[i] == E_IDLE) begin
        free_id = ID_WIDTH'(i);
      end
      if (st_q[i] != E_IDLE && data_q[i][IDX_LSB +: INDEX_WIDTH] == lkp_index) begin
        lkp_hit    = 1'b1;
        lkp_hit_id = ID_WIDTH'(i);
      end
      if (st_q[i] == E_DONE && !(rel_fire && rel_id_q == ID_WIDTH'(i))) begin
        done_found = 1'b1;
        done_id    = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      st_d[i]   = st_q[i];
      data_d[i] = data_q[i];
      ev_p_d[i] = ev_p_q[i];
      lf_p_d[i] = lf_p_q[i];
      if (rel_fire && rel_id_q == ID_WIDTH'(i)) begin
        st_d[i] = E_IDLE;
      end else if (accept && free_id == ID_WIDTH'(i)) begin
        data_d[i] = STATE_W'(alloc_state);
        ev_p_d[i] = alloc_state.need_evict;
        lf_p_d[i] = alloc_state.need_linefill;
        st_d[i]   = (alloc_state.need_evict || alloc_state.need_linefill) ? E_WAIT : E_DONE;
      end else if (st_q[i] == E_WAIT) begin
        if (evict_done_vld && evict_done_id == ID_WIDTH'(i)) ev_p_d[i] = 1'b0;
        if (lfill_done_vld && lfill_done_id == ID_WIDTH'(i)) lf_p_d[i] = 1'b0;
        if (!ev_p_d[i] && !lf_p_d[i]) st_d[i] = E_DONE;
      end
    end
  end

  // Release register reloads only when empty or its current entry is being taken.
  always_comb begin
    rel_vld_d   = rel_vld_q;
    rel_id_d    = rel_id_q;
    rel_state_d = rel_state_q;
    if (!rel_vld_q || rel_fire) begin
      rel_vld_d   = done_found;
      rel_id_d    = done_id;
      rel_state_d = done_found ? pack_l1d_mshr_state'(data_q[done_id]) : '0;
    end
  end

  always_comb begin
    busy_d = busy_q;
    case ({accept, rel_fire})
      2'b10:   busy_d = busy_q + 1'b1;
      2'b01:   busy_d = busy_q - 1'b1;
      default: busy_d = busy_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        st_q[i]   <= E_IDLE;
        data_q[i] <= '0;
      end
      ev_p_q      <= '0;
      lf_p_q      <= '0;
      rel_vld_q   <= 1'b0;
      rel_id_q    <= '0;
      rel_state_q <= '0;
      busy_q      <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        st_q[i]   <= st_d[i];
        data_q[i] <= data_d[i];
      end
      ev_p_q      <= ev_p_d;
      lf_p_q      <= lf_p_d;
      rel_vld_q   <= rel_vld_d;
      rel_id_q    <= rel_id_d;
      rel_state_q <= rel_state_d;
      busy_q      <= busy_d;
    end
  end

endmodule
